// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter that merges NCH core bus requesters (ibus, dbus and any
// later PTW/CSR/DMA ports) onto the single downstream memory/cache port.
// Only one transaction is in flight at a time. The winning request is latched
// at grant, presented downstream from registers until down_data_ok_i, and the
// completion is steered back to the owning channel.
//
// Optional feature (compile-time macro): BUS_ARB_TIMEOUT_EN
//   Defined     : a 16-bit watchdog aborts a transaction after TMO_CYC BUSY
//                 cycles without down_data_ok_i. The owner then sees
//                 ch_data_ok_o and ch_err_o together, with ch_rdata_o = 0.
//   Not defined : no watchdog; ch_err_o is constant 0 and BUSY waits for
//                 down_data_ok_i indefinitely.
//
// Parameters
//   NCH      number of requesting channels (>= 2)
//   AW       address width
//   DW       data width (strobe width DW/8)
//   TMO_CYC  watchdog limit in cycles (used only with BUS_ARB_TIMEOUT_EN)
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   ch_valid_i      per-channel request valid, held until that channel's data_ok
//   ch_addr_i       per-channel address, channel i at [i*AW +: AW]
//   ch_size_i       per-channel size code, channel i at [i*3 +: 3]
//   ch_strobe_i     per-channel write strobe (all-zero = read)
//   ch_wdata_i      per-channel write data
//   ch_rdata_o      read data broadcast to all channels
//   ch_data_ok_o    one-hot completion pulse to the owner
//   ch_err_o        one-hot error pulse, coincident with ch_data_ok_o (timeout)
//   down_valid_o    downstream request valid (high for the whole BUSY state)
//   down_addr_o     downstream address (latched)
//   down_size_o     downstream size (latched)
//   down_strobe_o   downstream strobe (latched)
//   down_wdata_o    downstream write data (latched)
//   down_rdata_i    downstream read data
//   down_data_ok_i  downstream completion, only meaningful while down_valid_o=1
//   busy_o          1 while a transaction is in flight
//   grant_id_o      index of the current owner (meaningful while busy_o=1)
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter  int NCH     = 2,
  parameter  int AW      = 64,
  parameter  int DW      = 64,
  parameter  int TMO_CYC = 256,
  localparam int SW      = DW / 8,
  localparam int GW      = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_valid_i,
  input  logic [NCH*AW-1:0] ch_addr_i,
  input  logic [NCH*3-1:0]  ch_size_i,
  input  logic [NCH*SW-1:0] ch_strobe_i,
  input  logic [NCH*DW-1:0] ch_wdata_i,
  output logic [DW-1:0]     ch_rdata_o,
  output logic [NCH-1:0]    ch_data_ok_o,
  output logic [NCH-1:0]    ch_err_o,
  output logic              down_valid_o,
  output logic [AW-1:0]     down_addr_o,
  output logic [2:0]        down_size_o,
  output logic [SW-1:0]     down_strobe_o,
  output logic [DW-1:0]     down_wdata_o,
  input  logic [DW-1:0]     down_rdata_i,
  input  logic              down_data_ok_i,
  output logic              busy_o,
  output logic [GW-1:0]     grant_id_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [SW-1:0] strobe_q, strobe_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          pick_vld;
  logic [GW-1:0] pick_idx;
  logic          is_busy;
  logic          tmo_hit;
  logic          finish;

  assign is_busy = (state_q == ST_BUSY);

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid channel scanning rr_ptr, rr_ptr+1, ... with
  // wrap at NCH (not at 2**GW, so non-power-of-two channel counts work).
  // ---------------------------------------------------------------------------
  always_comb begin
    int            cand;
    logic [GW-1:0] cand_idx;
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    cand     = 0;
    cand_idx = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      cand_idx = GW'(cand);
      if (!pick_vld && ch_valid_i[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional downstream watchdog
  // ---------------------------------------------------------------------------
`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Fires in the TMO_CYC-th BUSY cycle unless the downstream answers in it.
  assign tmo_hit = is_busy && !down_data_ok_i && (tmo_cnt_q == 16'(TMO_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!is_busy && pick_vld) begin
      tmo_cnt_d = '0;
    end else if (is_busy && !down_data_ok_i) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A transaction ends on the downstream answer or on a watchdog abort.
  assign finish = is_busy && (down_data_ok_i || tmo_hit);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. down_data_ok_i is ignored in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_vld) state_d = ST_BUSY;
      ST_BUSY: if (finish)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The completion path is combinational from down_data_ok_i;
  // ch_rdata_o passes the downstream data through except on a watchdog abort.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = is_busy;
    down_valid_o = is_busy;
    ch_data_ok_o = '0;
    ch_err_o     = '0;
    ch_rdata_o   = down_rdata_i;
    if (finish) begin
      ch_data_ok_o[grant_id_q] = 1'b1;
    end
    if (tmo_hit) begin
      ch_err_o[grant_id_q] = 1'b1;
      ch_rdata_o           = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    if (!is_busy && pick_vld) begin
      grant_id_d = pick_idx;
      addr_d     = ch_addr_i[pick_idx*AW +: AW];
      size_d     = ch_size_i[pick_idx*3 +: 3];
      strobe_d   = ch_strobe_i[pick_idx*SW +: SW];
      wdata_d    = ch_wdata_i[pick_idx*DW +: DW];
    end
    // The channel after the owner gets first look next time; this bounds any
    // held request's wait to NCH transactions.
    if (finish) begin
      rr_ptr_d = (grant_id_q == GW'(NCH - 1)) ? '0 : grant_id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
    end
  end

  // Downstream request comes only from registers: no ch_* -> down_* path.
  assign down_addr_o   = addr_q;
  assign down_size_o   = size_q;
  assign down_strobe_o = strobe_q;
  assign down_wdata_o  = wdata_q;
  assign grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Bench for bus_rr_arbiter with three channels, so the same instance covers the
// single-channel cases and three-way fairness. Expected completions (owner,
// read data, error flag) are queued as each request is issued and a monitor
// pops and compares them whenever the arbiter pulses a completion. A simple
// downstream responder answers after a programmable number of BUSY cycles.
// Define BUS_ARB_TIMEOUT_EN for both files to include the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int NCH     = 3;
  localparam int AW      = 64;
  localparam int DW      = 64;
  localparam int SW      = DW / 8;
  localparam int TMO_CYC = 8;
  localparam int GW      = $clog2(NCH);

  localparam logic [DW-1:0] BUSY_JUNK = 64'h0BAD_F00D_0BAD_F00D;
  localparam logic [DW-1:0] IDLE_DATA = 64'h1111_2222_3333_4444;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*3-1:0]  ch_size;
  logic [NCH*SW-1:0] ch_strobe;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ch_rdata_o;
  logic [NCH-1:0]    ch_data_ok_o;
  logic [NCH-1:0]    ch_err_o;
  logic              down_valid_o;
  logic [AW-1:0]     down_addr_o;
  logic [2:0]        down_size_o;
  logic [SW-1:0]     down_strobe_o;
  logic [DW-1:0]     down_wdata_o;
  logic [DW-1:0]     down_rdata;
  logic              down_data_ok;
  logic              busy_o;
  logic [GW-1:0]     grant_id_o;

  typedef struct {
    int            ch;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   req_left[NCH];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Downstream responder controls
  int            resp_lat     = 0;
  bit            resp_en      = 1'b1;
  bit            resp_fixed   = 1'b0;
  bit            resp_idle_ok = 1'b0;
  logic [DW-1:0] resp_rdata   = '0;
  int            wait_cnt     = 0;

  bus_rr_arbiter #(
    .NCH    (NCH),
    .AW     (AW),
    .DW     (DW),
    .TMO_CYC(TMO_CYC)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .ch_valid_i    (ch_valid),
    .ch_addr_i     (ch_addr),
    .ch_size_i     (ch_size),
    .ch_strobe_i   (ch_strobe),
    .ch_wdata_i    (ch_wdata),
    .ch_rdata_o    (ch_rdata_o),
    .ch_data_ok_o  (ch_data_ok_o),
    .ch_err_o      (ch_err_o),
    .down_valid_o  (down_valid_o),
    .down_addr_o   (down_addr_o),
    .down_size_o   (down_size_o),
    .down_strobe_o (down_strobe_o),
    .down_wdata_o  (down_wdata_o),
    .down_rdata_i  (down_rdata),
    .down_data_ok_i(down_data_ok),
    .busy_o        (busy_o),
    .grant_id_o    (grant_id_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read data returned for an address, so each channel's data is distinct.
  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  // Downstream responder: answers in BUSY cycle number resp_lat (0-based).
  initial begin
    down_data_ok = 1'b0;
    down_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (down_valid_o) begin
        if (resp_en && wait_cnt >= resp_lat) begin
          down_data_ok = 1'b1;
          down_rdata   = resp_fixed ? resp_rdata : rd_of(down_addr_o);
        end else begin
          down_data_ok = 1'b0;
          down_rdata   = BUSY_JUNK;
        end
        wait_cnt++;
      end else begin
        wait_cnt     = 0;
        down_data_ok = resp_idle_ok;
        down_rdata   = IDLE_DATA;
      end
    end
  end

  // Requesters: each channel drops valid after its last completion pulse.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (ch_data_ok_o[i] && req_left[i] > 0) begin
        req_left[i]--;
        if (req_left[i] == 0) ch_valid[i] = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every completion must match the head of exp_q.
  initial begin
    exp_t           e;
    logic [NCH-1:0] eok;
    logic [NCH-1:0] eerr;
    forever begin
      @(negedge clk);
      if (!reset && (ch_data_ok_o != '0 || ch_err_o != '0)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_completion: data_ok=%b err=%b busy=%b, required no completion",
                   ch_data_ok_o, ch_err_o, busy_o);
        end else begin
          e        = exp_q.pop_front();
          eok      = '0;
          eok[e.ch] = 1'b1;
          eerr     = e.err ? eok : '0;
          if (ch_data_ok_o !== eok || ch_err_o !== eerr || ch_rdata_o !== e.rdata || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL completion_ch%0d: data_ok=%b err=%b rdata=%h busy=%b, required data_ok=%b err=%b rdata=%h busy=1",
                     e.ch, ch_data_ok_o, ch_err_o, ch_rdata_o, busy_o, eok, eerr, e.rdata);
          end
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [2:0] sz,
                        input logic [SW-1:0] st, input logic [DW-1:0] wd, input int n);
    ch_addr[ch*AW +: AW]   = a;
    ch_size[ch*3 +: 3]     = sz;
    ch_strobe[ch*SW +: SW] = st;
    ch_wdata[ch*DW +: DW]  = wd;
    req_left[ch]           = n;
    ch_valid[ch]           = 1'b1;
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] rd, input bit err);
    exp_t e;
    e.ch    = ch;
    e.rdata = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic clear_reqs();
    ch_valid = '0;
    for (int i = 0; i < NCH; i++) req_left[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d completions outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    ch_valid = '1;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (down_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_down_valid: got %b, required 0", down_valid_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    if (ch_data_ok_o !== '0) begin n_fail++; $display("FAIL reset_data_ok: got %b, required 000", ch_data_ok_o); end
    if (ch_err_o !== '0) begin n_fail++; $display("FAIL reset_err: got %b, required 000", ch_err_o); end
    if (grant_id_o !== '0) begin n_fail++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id_o); end
    clear_reqs();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_no_stale_grant: busy=%b, required 0", busy_o); end
  endtask

  task automatic test_single_read();
    int t0;
    resp_fixed = 1'b1;
    resp_rdata = 64'h0000_0000_DEAD_BEEF;
    resp_lat   = 2;
    done_cyc.delete();
    @(negedge clk);
    set_ch(0, 64'h0000_0000_8000_1000, 3'd2, '0, '0, 1);
    push_exp(0, 64'h0000_0000_DEAD_BEEF, 1'b0);
    t0 = cyc;
    @(negedge clk);
    n_checks += 4;
    if (down_valid_o !== 1'b1) begin n_fail++; $display("FAIL read_latency: down_valid=%b one cycle after request, required 1", down_valid_o); end
    if (down_addr_o !== 64'h0000_0000_8000_1000) begin n_fail++; $display("FAIL read_addr: got %h, required 0000000080001000", down_addr_o); end
    if (down_strobe_o !== '0 || down_size_o !== 3'd2) begin n_fail++; $display("FAIL read_strobe_size: strobe=%h size=%0d, required 00 / 2", down_strobe_o, down_size_o); end
    if (grant_id_o !== 2'd0) begin n_fail++; $display("FAIL read_grant: got %0d, required 0", grant_id_o); end
    wait_done(20, "read");
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t0 + 3) begin
      n_fail++;
      $display("FAIL read_done_cycle: got %0d completions (first at +%0d), required 1 at +3",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1);
    end
    resp_fixed = 1'b0;
  endtask

  task automatic test_fairness();
    logic [AW-1:0] a [NCH];
    do_reset();
    resp_lat = 1;
    done_cyc.delete();
    a[0] = 64'h0000_0000_8000_0100;
    a[1] = 64'h0000_0000_8000_0200;
    a[2] = 64'h0000_0000_8000_0300;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) set_ch(i, a[i], 3'd3, '0, '0, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NCH; i++) push_exp(i, rd_of(a[i]), 1'b0);
    wait_done(60, "fair");
    n_checks++;
    if (done_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL fair_count: got %0d completions, required 6", done_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_checks++;
        if (done_cyc[i] - done_cyc[i-1] != 3) begin
          n_fail++;
          $display("FAIL fair_spacing_%0d: got %0d cycles, required 3", i, done_cyc[i] - done_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_write_fwd();
    bit found;
    resp_lat = 3;
    @(negedge clk);
    set_ch(0, 64'h0000_0000_8000_2000, 3'd3, '0, '0, 1);
    push_exp(0, rd_of(64'h0000_0000_8000_2000), 1'b0);
    @(negedge clk);
    set_ch(1, 64'h0000_0000_8010_0008, 3'd3, 8'hFF, 64'h1234, 1);
    push_exp(1, rd_of(64'h0000_0000_8010_0008), 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_o && grant_id_o == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL wr_grant: ch1 not granted within 20 cycles, required grant"); end
    for (int pass = 0; pass < 2; pass++) begin
      n_checks++;
      if (down_valid_o !== 1'b1 || down_addr_o !== 64'h0000_0000_8010_0008 || down_strobe_o !== 8'hFF ||
          down_wdata_o !== 64'h1234 || down_size_o !== 3'd3) begin
        n_fail++;
        $display("FAIL wr_forward_%0d: valid=%b addr=%h strobe=%h wdata=%h size=%0d, required 1/0000000080100008/ff/0000000000001234/3",
                 pass, down_valid_o, down_addr_o, down_strobe_o, down_wdata_o, down_size_o);
      end
      // The owner changes its inputs; the downstream request must not move.
      ch_addr[AW +: AW]   = '0;
      ch_strobe[SW +: SW] = '0;
      ch_wdata[DW +: DW]  = '1;
      ch_size[3 +: 3]     = 3'd0;
      @(negedge clk);
    end
    wait_done(20, "wr");
  endtask

  task automatic test_owner_drop();
    resp_lat = 2;
    @(negedge clk);
    set_ch(2, 64'h0000_0000_8000_3000, 3'd2, '0, '0, 1);
    push_exp(2, rd_of(64'h0000_0000_8000_3000), 1'b0);
    @(negedge clk);
    n_checks++;
    if (grant_id_o !== 2'd2 || busy_o !== 1'b1) begin n_fail++; $display("FAIL drop_grant: grant=%0d busy=%b, required 2/1", grant_id_o, busy_o); end
    ch_valid[2] = 1'b0;
    req_left[2] = 0;
    wait_done(20, "drop");
  endtask

  task automatic test_idle_noise();
    resp_idle_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || ch_rdata_o !== IDLE_DATA) begin
        n_fail++;
        $display("FAIL idle_noise: busy=%b rdata=%h, required 0/%h", busy_o, ch_rdata_o, IDLE_DATA);
      end
    end
    resp_idle_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    // One completion on ch0 moves the pointer to 1 before the abort.
    resp_lat = 0;
    @(negedge clk);
    set_ch(0, 64'h0000_0000_8000_4000, 3'd3, '0, '0, 1);
    push_exp(0, rd_of(64'h0000_0000_8000_4000), 1'b0);
    wait_done(20, "pre_abort");
    resp_en = 1'b0;
    set_ch(2, 64'h0000_0000_8000_5000, 3'd3, '0, '0, 1);
    @(negedge clk);
    n_checks++;
    if (grant_id_o !== 2'd2) begin n_fail++; $display("FAIL abort_grant: got %0d, required 2", grant_id_o); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (down_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_down_valid: got %b, required 0", down_valid_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy_o); end
    if (grant_id_o !== 2'd0) begin n_fail++; $display("FAIL abort_grant_id: got %0d, required 0", grant_id_o); end
    clear_reqs();
    reset   = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    // Pointer back at 0: with ch0 and ch1 requesting together ch0 must win.
    set_ch(1, 64'h0000_0000_8000_6100, 3'd3, '0, '0, 1);
    set_ch(0, 64'h0000_0000_8000_6000, 3'd3, '0, '0, 1);
    push_exp(0, rd_of(64'h0000_0000_8000_6000), 1'b0);
    push_exp(1, rd_of(64'h0000_0000_8000_6100), 1'b0);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || grant_id_o !== 2'd0) begin n_fail++; $display("FAIL abort_rr_ptr: busy=%b grant=%0d, required 1/0", busy_o, grant_id_o); end
    wait_done(20, "post_abort");
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    resp_en = 1'b0;
    done_cyc.delete();
    @(negedge clk);
    // Pointer is at 2 and ch2 is idle, so ch0 wins, then ch1 follows.
    set_ch(0, 64'h0000_0000_8000_7000, 3'd3, '0, '0, 1);
    set_ch(1, 64'h0000_0000_8000_7100, 3'd3, '0, '0, 1);
    push_exp(0, '0, 1'b1);
    push_exp(1, rd_of(64'h0000_0000_8000_7100), 1'b0);
    t0 = cyc;
    for (int k = 0; k < 30 && done_cyc.size() == 0; k++) @(negedge clk);
    resp_en  = 1'b1;
    resp_lat = 0;
    wait_done(20, "tmo");
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != t0 + TMO_CYC) begin
      n_fail++;
      $display("FAIL tmo_cycle: got %0d completions (first at +%0d), required 2 with first at +%0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, TMO_CYC);
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    ch_valid  = '0;
    ch_addr   = '0;
    ch_size   = '0;
    ch_strobe = '0;
    ch_wdata  = '0;
    for (int i = 0; i < NCH; i++) req_left[i] = 0;
    test_reset();
    test_single_read();
    test_fairness();
    test_write_fwd();
    test_owner_drop();
    test_idle_noise();
    test_reset_midop();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL final_state: outstanding=%0d busy=%b, required 0/0", exp_q.size(), busy_o);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
